// File: rtl/fifo_r.sv
// fifo_r: read-side byte FIFO for the AHB master data path.
//   Stores 32-bit HRDATA words in a circular buffer and emits them one byte
//   per READ-mode shift, least-significant byte first. A registered one-cycle
//   pulse marks the output of the last byte of each word.
//
// Parameters:
//   DEPTH_WORDS               number of 32-bit word slots (power of two, >= 2)
// Ports:
//   HCLK                      system clock, rising edge
//   HRESETn                   asynchronous active-low reset
//   status[1:0]               bus mode: 00 IDLE, 01 WRITE, 10 READ, 11 ERROR
//   shift_enable              pop one byte (honoured only in READ, non-empty)
//   load_enable               push HRDATA as one word (ignored when full)
//   HRDATA[31:0]              AHB read data
//   data_in[7:0]              registered byte output
//   transfer_data_complete_r  registered pulse after byte 3 of a word
// Build option:
//   FIFO_R_ERROR_FLUSH_EN     when defined, status ERROR at an edge empties the
//                             FIFO and drops a same-cycle load; otherwise ERROR
//                             holds like IDLE.

module fifo_r #(
  parameter int unsigned DEPTH_WORDS = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [1:0]  status,
  input  logic        shift_enable,
  input  logic        load_enable,
  input  logic [31:0] HRDATA,
  output logic [7:0]  data_in,
  output logic        transfer_data_complete_r
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(DEPTH_WORDS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_READ  = 2'b10,
    ST_ERROR = 2'b11
  } bus_status_e;

  bus_status_e mode;

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [1:0]    byte_q, byte_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;

  logic          full, empty, flush;
  logic          do_load, do_shift, retire;
  logic [31:0]   head_word;
  logic [7:0]    head_byte;

  assign mode = bus_status_e'(status);

  always_comb begin
    full      = (count_q == CW'(DEPTH_WORDS));
    empty     = (count_q == '0);
`ifdef FIFO_R_ERROR_FLUSH_EN
    flush     = (mode == ST_ERROR);
`else
    flush     = 1'b0;
`endif
    // Fullness and emptiness use the pre-edge count, so a word loaded this
    // cycle is never shifted this cycle and a retire never frees a slot early.
    do_load   = load_enable && !full && !flush;
    do_shift  = shift_enable && (mode == ST_READ) && !empty;
    retire    = do_shift && (byte_q == 2'd3);

    head_word = mem_q[rptr_q];
    case (byte_q)
      2'd0:    head_byte = head_word[7:0];
      2'd1:    head_byte = head_word[15:8];
      2'd2:    head_byte = head_word[23:16];
      default: head_byte = head_word[31:24];
    endcase

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    byte_d  = byte_q;
    count_d = count_q;
    data_d  = data_q;
    done_d  = 1'b0;

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      byte_d  = '0;
      count_d = '0;
    end else begin
      if (do_load) begin
        wptr_d = wptr_q + AW'(1);
      end
      if (do_shift) begin
        data_d = head_byte;
        byte_d = byte_q + 2'd1;
      end
      if (retire) begin
        rptr_d = rptr_q + AW'(1);
        done_d = 1'b1;
      end
      count_d = count_q + CW'(do_load) - CW'(retire);
    end
  end

  // Word storage needs no reset: count gates every read of it.
  always_ff @(posedge HCLK) begin
    if (do_load) begin
      mem_q[wptr_q] <= HRDATA;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      byte_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      byte_q  <= byte_d;
      count_q <= count_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign data_in                  = data_q;
  assign transfer_data_complete_r = done_q;

endmodule

// File: tb/tb_fifo_r.sv
module tb_fifo_r;

  logic        HCLK;
  logic        HRESETn;
  logic [1:0]  status;
  logic        shift_enable;
  logic        load_enable;
  logic [31:0] HRDATA;
  logic [7:0]  data_in;
  logic        transfer_data_complete_r;

  int unsigned n_cmp;
  int unsigned n_bad;

  fifo_r #(.DEPTH_WORDS(2)) dut (
    .HCLK                     (HCLK),
    .HRESETn                  (HRESETn),
    .status                   (status),
    .shift_enable             (shift_enable),
    .load_enable              (load_enable),
    .HRDATA                   (HRDATA),
    .data_in                  (data_in),
    .transfer_data_complete_r (transfer_data_complete_r)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Push one word with the bus idle.
  task automatic load_word(input logic [31:0] w);
    status       = 2'b00;
    shift_enable = 1'b0;
    load_enable  = 1'b1;
    HRDATA       = w;
    tick();
    load_enable  = 1'b0;
  endtask

  task automatic test_reset();
    HRESETn      = 1'b0;
    status       = 2'b00;
    shift_enable = 1'b0;
    load_enable  = 1'b0;
    HRDATA       = '0;
    repeat (3) @(posedge HCLK);
    #1;
    n_cmp++;
    if (data_in !== 8'h00) begin
      $display("FAIL reset_data: got %h want 00", data_in); n_bad++;
    end
    n_cmp++;
    if (transfer_data_complete_r !== 1'b0) begin
      $display("FAIL reset_done: got %b want 0", transfer_data_complete_r); n_bad++;
    end
    HRESETn      = 1'b1;
    status       = 2'b10;
    shift_enable = 1'b1;
    tick();
    n_cmp++;
    if (data_in !== 8'h00 || transfer_data_complete_r !== 1'b0) begin
      $display("FAIL empty_shift: got %h/%b want 00/0", data_in, transfer_data_complete_r); n_bad++;
    end
    shift_enable = 1'b0;
  endtask

  task automatic test_basic();
    logic [1:0] st [8] = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [7:0] eb [8] = '{8'h85, 8'h85, 8'h85, 8'h64, 8'h32, 8'h12, 8'h12, 8'h12};
    logic       ed [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    load_word(32'h12326485);
    for (int i = 0; i < 8; i++) begin
      status       = st[i];
      shift_enable = 1'b1;
      tick();
      n_cmp++;
      if (data_in !== eb[i] || transfer_data_complete_r !== ed[i]) begin
        $display("FAIL basic[%0d]: got %h/%b want %h/%b", i, data_in, transfer_data_complete_r, eb[i], ed[i]);
        n_bad++;
      end
    end
    shift_enable = 1'b0;
  endtask

  task automatic test_second();
    logic [7:0] eb [4] = '{8'h80, 8'h2F, 8'h49, 8'h13};
    int unsigned pulses = 0;
    load_word(32'h13492F80);
    for (int i = 0; i < 4; i++) begin
      status       = 2'b10;
      shift_enable = 1'b1;
      tick();
      if (transfer_data_complete_r === 1'b1) pulses++;
      n_cmp++;
      if (data_in !== eb[i]) begin
        $display("FAIL second[%0d]: got %h want %h", i, data_in, eb[i]); n_bad++;
      end
    end
    n_cmp++;
    if (pulses != 1) begin
      $display("FAIL second_pulses: got %0d want 1", pulses); n_bad++;
    end
    shift_enable = 1'b0;
  endtask

  task automatic test_full();
    logic [7:0] eb [9] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB3};
    logic       ed [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    load_word(32'hA3A2A1A0);
    load_word(32'hB3B2B1B0);
    load_word(32'hC3C2C1C0);
    for (int i = 0; i < 9; i++) begin
      status       = 2'b10;
      shift_enable = 1'b1;
      tick();
      n_cmp++;
      if (data_in !== eb[i] || transfer_data_complete_r !== ed[i]) begin
        $display("FAIL full[%0d]: got %h/%b want %h/%b", i, data_in, transfer_data_complete_r, eb[i], ed[i]);
        n_bad++;
      end
    end
    shift_enable = 1'b0;
  endtask

  // Full FIFO retiring a word while a load arrives: the load is rejected.
  task automatic test_full_retire();
    logic [7:0] eb [9] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60, 8'h61, 8'h62, 8'h63, 8'h63};
    logic       ed [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    load_word(32'h53525150);
    load_word(32'h63626160);
    for (int i = 0; i < 9; i++) begin
      status       = 2'b10;
      shift_enable = 1'b1;
      load_enable  = (i == 3);
      HRDATA       = 32'h73727170;
      tick();
      n_cmp++;
      if (data_in !== eb[i] || transfer_data_complete_r !== ed[i]) begin
        $display("FAIL full_retire[%0d]: got %h/%b want %h/%b", i, data_in, transfer_data_complete_r, eb[i], ed[i]);
        n_bad++;
      end
    end
    load_enable  = 1'b0;
    shift_enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] eb [9] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    logic       ed [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    load_word(32'h44332211);
    for (int i = 0; i < 9; i++) begin
      status       = 2'b10;
      shift_enable = 1'b1;
      load_enable  = (i == 3);
      HRDATA       = 32'h88776655;
      tick();
      n_cmp++;
      if (data_in !== eb[i] || transfer_data_complete_r !== ed[i]) begin
        $display("FAIL b2b[%0d]: got %h/%b want %h/%b", i, data_in, transfer_data_complete_r, eb[i], ed[i]);
        n_bad++;
      end
    end
    load_enable  = 1'b0;
    shift_enable = 1'b0;
  endtask

  task automatic test_flush();
`ifdef FIFO_R_ERROR_FLUSH_EN
    logic [7:0] eb [8] = '{8'hD0, 8'hD0, 8'hD0, 8'hD0, 8'hD0, 8'hD0, 8'hD0, 8'hD0};
    logic       ed [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    logic [7:0] eb [8] = '{8'hD1, 8'hD2, 8'hD3, 8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE3};
    logic       ed [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
    load_word(32'hD3D2D1D0);
    load_word(32'hE3E2E1E0);
    status       = 2'b10;
    shift_enable = 1'b1;
    tick();
    n_cmp++;
    if (data_in !== 8'hD0) begin
      $display("FAIL flush_first: got %h want d0", data_in); n_bad++;
    end
    status = 2'b11;
    tick();
    n_cmp++;
    if (data_in !== 8'hD0 || transfer_data_complete_r !== 1'b0) begin
      $display("FAIL flush_hold: got %h/%b want d0/0", data_in, transfer_data_complete_r); n_bad++;
    end
    for (int i = 0; i < 8; i++) begin
      status = 2'b10;
      tick();
      n_cmp++;
      if (data_in !== eb[i] || transfer_data_complete_r !== ed[i]) begin
        $display("FAIL flush_drain[%0d]: got %h/%b want %h/%b", i, data_in, transfer_data_complete_r, eb[i], ed[i]);
        n_bad++;
      end
    end
`ifdef FIFO_R_ERROR_FLUSH_EN
    status      = 2'b11;
    load_enable = 1'b1;
    HRDATA      = 32'hF3F2F1F0;
    tick();
    load_enable = 1'b0;
    status      = 2'b10;
    tick();
    n_cmp++;
    if (data_in !== 8'hD0) begin
      $display("FAIL flush_load_drop: got %h want d0", data_in); n_bad++;
    end
`endif
    shift_enable = 1'b0;
  endtask

  task automatic test_reset_mid();
    load_word(32'hAABBCCDD);
    status       = 2'b10;
    shift_enable = 1'b1;
    tick();
    n_cmp++;
    if (data_in !== 8'hDD) begin
      $display("FAIL mid_first: got %h want dd", data_in); n_bad++;
    end
    shift_enable = 1'b0;
    HRESETn      = 1'b0;
    #1;
    n_cmp++;
    if (data_in !== 8'h00 || transfer_data_complete_r !== 1'b0) begin
      $display("FAIL mid_async: got %h/%b want 00/0", data_in, transfer_data_complete_r); n_bad++;
    end
    tick();
    HRESETn      = 1'b1;
    shift_enable = 1'b1;
    tick();
    n_cmp++;
    if (data_in !== 8'h00) begin
      $display("FAIL mid_discard: got %h want 00", data_in); n_bad++;
    end
    shift_enable = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_second();
    test_full();
    test_full_retire();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
